// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, CPOL/CPHA helpers, byte width,
// fill byte and the responder state type.
package spi_pkg;

    localparam int SPI_MODE0 = 0;
    localparam int SPI_MODE1 = 1;
    localparam int SPI_MODE2 = 2;
    localparam int SPI_MODE3 = 3;

    localparam int                BYTE_W    = 8;
    localparam logic [BYTE_W-1:0] FILL_BYTE = 8'h00;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for an asynchronous pin followed by registered
// one-cycle rise/fall pulses (pin-to-pulse latency SYNC_STAGES+1 cycles).
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI responder, fully in the i_Clk domain (oversampled pins).
// Define SPI_SLAVE_MISO_TRISTATE_EN to release MISO (1'bz) while idle.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MODE    = SPI_MODE0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [BYTE_W-1:0] i_TX_Byte,
    input  logic              i_TX_DV,
    output logic              o_TX_Ready,
    output logic              o_RX_DV,
    output logic [BYTE_W-1:0] o_RX_Byte,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO
);

    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_async (i_SPI_Clk),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_async (i_SPI_CS_n),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]      rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]      rx_byte_q, rx_byte_d;
    logic                   rx_dv_q, rx_dv_d;
    logic [BYTE_W-1:0]      tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   miso_q, miso_d;

    logic              mosi_bit, sample_edge, shift_edge, load;
    logic [BYTE_W-1:0] load_byte;

    assign mosi_bit    = mosi_sync_q[SYNC_STAGES-1];
    assign sample_edge = CPHA ? (CPOL ? sclk_rise : sclk_fall) : (CPOL ? sclk_fall : sclk_rise);
    assign shift_edge  = CPHA ? (CPOL ? sclk_fall : sclk_rise) : (CPOL ? sclk_rise : sclk_fall);
    assign load_byte   = hold_full_q ? hold_q : FILL_BYTE;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = 3'd0;
                    load      = 1'b1;
                    // CPHA=0 presents bit 7 at select; the first trailing edge then shifts bit 6.
                    if (!CPHA) begin
                        miso_d     = load_byte[BYTE_W-1];
                        tx_shift_d = load_byte << 1;
                    end else begin
                        tx_shift_d = load_byte;
                    end
                end
            end
            ST_ACTIVE: begin
                if (shift_edge) begin
                    miso_d     = tx_shift_q[BYTE_W-1];
                    tx_shift_d = tx_shift_q << 1;
                end
                if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[BYTE_W-3:0], mosi_bit};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_d  = {rx_shift_q, mosi_bit};
                        rx_dv_d    = 1'b1;
                        load       = 1'b1;
                        tx_shift_d = load_byte;
                    end
                end
                // A completing byte in the same cycle still delivers its RX pulse above.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            hold_full_d = 1'b0;
        end
        if (i_TX_DV && !hold_full_q) begin
            hold_d      = i_TX_Byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            mosi_sync_q <= '0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= '0;
            rx_byte_q   <= FILL_BYTE;
            rx_dv_q     <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
        end
    end

    assign o_TX_Ready = ~hold_full_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_SPI_MISO = (state_q == ST_ACTIVE) ? miso_q : 1'bz;
`else
    assign o_SPI_MISO = (state_q == ST_ACTIVE) ? miso_q : 1'b0;
`endif

endmodule

// File: doc/spi_slave.md
# spi_slave

Byte-oriented SPI responder running entirely in the system clock domain: the other end of the link driven by `SPI_Master`. Oversamples and synchronizes SCLK, CS_n and MOSI, deserializes MOSI into bytes and serializes a preloaded response byte onto MISO, MSB first. It sits between an off-chip or on-chip SPI initiator and a byte-level user handshake of the same style as the master's (`TX_DV`/`TX_Ready`, `RX_DV`/`RX_Byte`).

## Interface
- `SPI_MODE`, default 0: SPI mode 0–3. CPOL = bit 1 and CPHA = bit 0.
- `SYNC_STAGES`, default 2: flip-flop stages on each SPI input pin; legal range ≥2.
- `i_Clk` in 1: system clock. Every register is clocked on its rising edge.
- `i_Rst_L` in 1: asynchronous, active-low reset.
- `i_TX_Byte` in 8: response byte. Captured when `i_TX_DV`=1 and `o_TX_Ready`=1.
- `i_TX_DV` in 1: single-cycle strobe qualifying `i_TX_Byte`.
- `o_TX_Ready` out 1: holding register empty. A new byte is accepted.
- `o_RX_DV` out 1: single-cycle pulse. Marks `o_RX_Byte` as valid.
- `o_RX_Byte` out 8: last complete byte received on MOSI.
- `i_SPI_Clk` in 1: SCLK from the initiator, asynchronous to `i_Clk`.
- `i_SPI_CS_n` in 1: chip select, active-low, asynchronous.
- `i_SPI_MOSI` in 1: serial data from the initiator.
- `o_SPI_MISO` out 1: serial data to the initiator.

## Operation
- All three SPI pins pass through `SYNC_STAGES` flip-flops before use. Edges are detected on the synchronized signals only.
- Leading edge = first SCLK transition away from CPOL. Trailing edge = the return to CPOL.
- CPHA=0:
  - MOSI is sampled on the leading edge.
  - MISO shifts on the trailing edge.
  - MISO bit 7 is presented on the detected falling edge of CS_n.
- CPHA=1:
  - MISO shifts on the leading edge. Bit 7 is presented on the first leading edge.
  - MOSI is sampled on the trailing edge.
- State machine:
  - IDLE (CS_n high) → ACTIVE on the synchronized CS_n falling edge. On entry, the shift register loads from the holding register.
  - ACTIVE → IDLE on the synchronized CS_n rising edge, from any bit position.
- Bit counter 3 bits, counting sample edges. On the 8th sample:
  - Counter wraps 7→0.
  - `o_RX_Byte` updates and `o_RX_DV` pulses.
  - The TX shift register reloads from the holding register, so multi-byte bursts run with CS held low.
- TX holding register:
  - `o_TX_Ready` drops the cycle after acceptance.
  - It rises again when the shift register consumes the byte.
  - If empty at a load point, 8'h00 is transmitted.
- CS_n deasserted mid-byte:
  - Partial RX byte is discarded; no `o_RX_DV`.
  - Bit counter clears.
  - Any unconsumed holding-register byte is retained.
- `i_TX_DV` while `o_TX_Ready`=0: ignored. The holding register is not overwritten.
- Reset values:
  - `o_TX_Ready`=1, `o_RX_DV`=0, `o_RX_Byte`=8'h00.
  - MISO at its idle value (see Configuration).
  - State IDLE, counter 0, holding register empty.

## Timing
- Pin-to-internal-edge latency: `SYNC_STAGES`+1 `i_Clk` cycles.
- `o_RX_DV` asserts exactly one cycle after the internal 8th sample edge and lasts one cycle.
- `o_SPI_MISO` changes exactly one cycle after the internal shift edge.
- Requirements on the initiator:
  - SCLK high time ≥4 `i_Clk` periods and SCLK low time ≥4 `i_Clk` periods.
  - CS_n setup before the first SCLK edge ≥4 `i_Clk` periods.
- A TX byte is guaranteed for the next transfer only if accepted ≥2 cycles before the internal load point.
- Simultaneous CS_n rising and 8th sample edge in the same cycle: the byte completes and `o_RX_DV` pulses.

## Configuration
- `SPI_SLAVE_MISO_TRISTATE_EN` defined: `o_SPI_MISO` is 1'bz whenever the block is in IDLE. This allows multiple responders on one MISO line.
- Macro undefined: `o_SPI_MISO` drives 1'b0 in IDLE and is never high-Z.

## Structure
- Shared package `spi_pkg`:
  - SPI mode constants (`SPI_MODE0`..`SPI_MODE3`) and CPOL/CPHA extraction functions.
  - Byte width constant (8).
  - Idle/fill byte constant (8'h00).
- One sub-module: `spi_edge_sync`. It provides a `SYNC_STAGES` synchronizer and one-cycle rise/fall pulses, and is instantiated for SCLK and CS_n. MOSI uses its synchronizer output only.

## Test plan
- Mode 0 loopback with `SPI_Master`: preload 8'h3C, master sends 8'hAA → slave `o_RX_Byte`=8'hAA with one `o_RX_DV` pulse, and the master receives 8'h3C.
- Modes 1–3 each: preload 8'hA5, master sends 8'h5A → `o_RX_Byte`=8'h5A and the master reads 8'hA5.
- Burst of three bytes with CS low, slave preloading 8'h01/8'h02 between bytes: master sends 8'h11/8'h22/8'h33 → three `o_RX_DV` pulses. Master reads 8'h01, 8'h02, then 8'h00 (empty).
- CS_n raised after 4 SCLK cycles of the 8'hF0 byte → no `o_RX_DV`. The next full transfer 8'h0F is received correctly.
- `i_Rst_L` pulsed low mid-byte → all outputs return to reset values immediately and `o_TX_Ready`=1.
- With `SPI_SLAVE_MISO_TRISTATE_EN`: MISO is z whenever CS_n=1. Without the macro: MISO is 0.
